// File: rtl/bcd2bin.sv
// Four-digit BCD to 16-bit binary converter (reverse double-dabble, one bit per clock).
// Optional input validation enabled by defining BCD2BIN_VALIDATE_EN.
module bcd2bin (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  bcd0,
   input  logic [3:0]  bcd1,
   input  logic [3:0]  bcd2,
   input  logic [3:0]  bcd3,
   output logic [15:0] bin,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int unsigned NIB_W  = 4;
   localparam int unsigned DIGITS = 4;
   localparam int unsigned BIN_W  = 16;
   localparam int unsigned CNT_W  = 4;
   localparam logic [CNT_W-1:0] LAST = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [BIN_W-1:0]   digit_reg, digit_nxt;
   logic [BIN_W-1:0]   result_reg, result_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [BIN_W-1:0]   bin_nxt;
   logic               busy_nxt, done_nxt, err_nxt;
   logic [BIN_W-1:0]   dig_sh, dig_adj, res_sh;
   logic               invalid;

`ifdef BCD2BIN_VALIDATE_EN
   assign invalid = (bcd0 > 4'd9) || (bcd1 > 4'd9) || (bcd2 > 4'd9) || (bcd3 > 4'd9);
`else
   assign invalid = 1'b0;
`endif

   // State, datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         digit_reg  <= '0;
         result_reg <= '0;
         cnt        <= '0;
         bin        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_nxt;
         digit_reg  <= digit_nxt;
         result_reg <= result_nxt;
         cnt        <= cnt_nxt;
         bin        <= bin_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
         err        <= err_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = invalid ? DONE : SHIFT;
         SHIFT:   if (cnt == LAST) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath step and next output values
   always_comb begin
      digit_nxt  = digit_reg;
      result_nxt = result_reg;
      cnt_nxt    = cnt;
      bin_nxt    = bin;
      busy_nxt   = 1'b0;
      done_nxt   = 1'b0;
      err_nxt    = 1'b0;

      // Digit LSB moves into result MSB; each nibble is corrected independently
      res_sh  = {digit_reg[0], result_reg[BIN_W-1:1]};
      dig_sh  = {1'b0, digit_reg[BIN_W-1:1]};
      dig_adj = dig_sh;
      for (int i = 0; i < DIGITS; i++) begin
         if (dig_sh[NIB_W*i + NIB_W-1])
            dig_adj[NIB_W*i +: NIB_W] = dig_sh[NIB_W*i +: NIB_W] - 4'd3;
      end

      case (state)
         IDLE: begin
            if (start) begin
               digit_nxt  = {bcd3, bcd2, bcd1, bcd0};
               result_nxt = '0;
               cnt_nxt    = '0;
               if (invalid) begin
                  done_nxt = 1'b1;
                  err_nxt  = 1'b1;
                  bin_nxt  = '0;
               end else begin
                  busy_nxt = 1'b1;
               end
            end
         end
         SHIFT: begin
            digit_nxt  = dig_adj;
            result_nxt = res_sh;
            cnt_nxt    = cnt + CNT_W'(1);
            if (cnt == LAST) begin
               done_nxt = 1'b1;
               bin_nxt  = res_sh;
            end else begin
               busy_nxt = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule
